alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
Registered execute-stage ALU that consumes the 4-bit ALU select code produced by the ALU control decode and applies it to two operands. It sits between the ID/EX pipeline register and the EX/MEM register. Valid/ready handshakes on both sides, with a 2-entry skid buffer, let downstream stalls back-pressure decode without losing an operation. Flags support branch resolution, and a saturating counter records completed operations.

Parameters:
XLEN, 32, operand/result width (>=8)
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation presented
in_ready  out  1  stage can accept operation
alusel  in  4  select code: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 1111 NOP
op_a  in  XLEN  operand A
op_b  in  XLEN  operand B
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
result  out  XLEN  operation result
zero  out  1  result == 0
carry  out  1  carry-out of ADD; NOT borrow of SUB (a >= b unsigned); 0 otherwise
ovf  out  1  signed overflow of ADD/SUB; 0 otherwise
neg  out  1  result[XLEN-1]
illegal  out  1  alusel not one of the five defined codes
op_count  out  CNT_W  completed transfers, saturating
clr_count  in  1  synchronous clear of op_count

Behaviour:
- Reset (async, rst_n=0): both buffer entries invalid; out_valid=0, in_ready=1 once released, result=0, all flags=0, op_count=0. Deassertion is synchronised externally. Any in-flight operation is discarded.
- Input transfer on in_valid & in_ready at a rising edge; output transfer on out_valid & out_ready.
- Result and flags are computed combinationally from the accepted operands and captured in the same cycle. Latency is 1 cycle: an op accepted at edge N has out_valid=1 after edge N.
- Storage: main output register plus one skid entry.
  - in_ready = skid entry empty (registered, no combinational path from out_ready).
  - Output register empty, or draining this cycle: the accepted op loads the output register.
  - Output register full and stalled: the accepted op loads the skid entry, and in_ready drops after the edge.
  - When the output drains with skid full: skid moves to output and the skid frees. A new op in the same cycle is impossible because in_ready=0.
  - Ordering is strictly FIFO.
- Arithmetic: ADD = a+b mod 2^XLEN. SUB = a-b computed as a+~b+1.
  - carry is the XLEN+1 bit of the adder in both cases.
  - ovf = (a[msb]==b'[msb]) & (r[msb]!=a[msb]), where b' = b for ADD and ~b for SUB.
- AND/OR are bitwise; carry=ovf=0.
- NOP: result=0, zero=1, all other flags 0, illegal=0.
- Any other alusel value: result=0, zero=1, carry=ovf=neg=0, illegal=1. The op still completes and is counted.
- op_count increments on each output transfer and saturates at 2^CNT_W-1. clr_count has priority over an increment in the same cycle.
- Output data holds stable while out_valid & !out_ready (AXI-style stability rule). result and flags may change only on a transfer or when an op loads an empty output register.
- Simultaneous in and out transfer with one entry held: output register reloads with the new op, skid stays empty, throughput is 1/cycle.

Test Plan:
- Reset mid-stream: fill both entries with out_ready=0, pulse rst_n low -> out_valid=0, in_ready=1, op_count=0, result=0 immediately (async).
- ADD overflow/carry: ADD 0x7FFFFFFF+1 -> result 0x80000000, ovf=1, carry=0, neg=1. ADD 0xFFFFFFFF+1 -> result 0, zero=1, carry=1, ovf=0.
- SUB compare: SUB 5-7 -> result 0xFFFFFFFE, carry=0, neg=1. SUB 7-5 -> result 2, carry=1. SUB 0x80000000-1 -> 0x7FFFFFFF, ovf=1.
- Logic and codes: AND 0xF0F0_00FF & 0x0FF0_0F0F -> 0x00F0_000F. OR of the same -> 0xFFF0_0FFF. NOP -> 0, zero=1. alusel=0101 -> illegal=1, result 0.
- Back-pressure: stream 4 ops with out_ready=0 -> exactly 2 accepted, in_ready=0 from the cycle after the 2nd. Release out_ready -> results emerge in order, data stable during the stall, op_count=4 after all drain.
- Counter: CNT_W=4, 17 transfers -> op_count=15. clr_count asserted with a simultaneous transfer -> 0.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU (ADD/SUB/AND/OR/NOP) with flags, 1-cycle registered latency.
// Output register plus one skid entry; in_ready is registered and drops only when the skid entry is occupied.
module alu_exec_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alusel,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             neg,
  output logic             illegal,
  output logic [CNT_W-1:0] op_count,
  input  logic             clr_count
);

  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_NOP = 4'b1111;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic            carry;
    logic            ovf;
    logic            neg;
    logic            illegal;
  } res_t;

  res_t          alu_res;
  res_t          out_q;
  res_t          skid_q;
  logic          skid_vld;
  logic          out_vld;
  logic          is_sub;
  logic [XLEN-1:0] b_eff;
  logic [XLEN:0]   sum;
  logic          in_fire;
  logic          out_fire;

  // SUB reuses the adder as a + ~b + 1, so carry is NOT borrow.
  assign is_sub = (alusel == SEL_SUB);
  assign b_eff  = is_sub ? ~op_b : op_b;
  assign sum    = {1'b0, op_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};

  always_comb begin
    alu_res = '0;
    case (alusel)
      SEL_ADD, SEL_SUB: begin
        alu_res.result = sum[XLEN-1:0];
        alu_res.carry  = sum[XLEN];
        alu_res.ovf    = (op_a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
      end
      SEL_AND: alu_res.result = op_a & op_b;
      SEL_OR:  alu_res.result = op_a | op_b;
      SEL_NOP: alu_res.result = '0;
      default: alu_res.illegal = 1'b1;
    endcase
    alu_res.zero = (alu_res.result == '0);
    alu_res.neg  = alu_res.result[XLEN-1];
  end

  assign in_ready = !skid_vld;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_vld && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_q    <= '0;
      skid_vld <= 1'b0;
      skid_q   <= '0;
    end else if (!out_vld || out_fire) begin
      // Output slot is free (or freeing): skid has priority to keep FIFO order.
      if (skid_vld) begin
        out_q    <= skid_q;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else if (in_fire) begin
        out_q   <= alu_res;
        out_vld <= 1'b1;
      end else begin
        out_vld <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q   <= alu_res;
      skid_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (clr_count) begin
      op_count <= '0;
    end else if (out_fire && (op_count != CNT_MAX)) begin
      op_count <= op_count + 1'b1;
    end
  end

  assign out_valid = out_vld;
  assign result    = out_q.result;
  assign zero      = out_q.zero;
  assign carry     = out_q.carry;
  assign ovf       = out_q.ovf;
  assign neg       = out_q.neg;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: ALU vectors, flags, skid back-pressure, counter saturation.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alusel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        carry;
  logic        ovf;
  logic        neg;
  logic        illegal;
  logic [3:0]  op_count;
  logic        clr_count;

  int tests;
  int failures;

  alu_exec_stage #(.XLEN(32), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alusel    (alusel),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .ovf       (ovf),
    .neg       (neg),
    .illegal   (illegal),
    .op_count  (op_count),
    .clr_count (clr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {illegal, neg, ovf, carry, zero};
  endfunction

  // Flag order: {illegal, neg, ovf, carry, zero}; pipeline idle and out_ready=1 on entry.
  task automatic single_op(input string tag, input logic [3:0] sel, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] er, input logic [4:0] ef);
    in_valid = 1'b1;
    alusel   = sel;
    op_a     = a;
    op_b     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_res"}, result, er);
    chk({tag, "_flg"}, flags(), ef);
    @(posedge clk); #1;
    chk({tag, "_drain"}, out_valid, 0);
  endtask

  logic [3:0]  bp_sel [4];
  logic [31:0] bp_a   [4];
  logic [31:0] bp_b   [4];
  logic [31:0] bp_exp [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic fin;
    logic fout;
    int   ii;
    int   oi;
    int   acc_rel;

    tests = 0; failures = 0;
    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; alusel = 4'b0; op_a = '0; op_b = '0;
    out_ready = 1'b0; clr_count = 1'b0;

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", result, 0);
    chk("rst_flags", flags(), 0);
    chk("rst_count", op_count, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-stream with both entries occupied.
    in_valid = 1'b1; alusel = 4'b0010; op_a = 32'd5; op_b = 32'd6;
    @(posedge clk); #1;
    op_a = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_full_in_ready", in_ready, 0);
    chk("mid_full_out_valid", out_valid, 1);
    chk("mid_full_result", result, 32'd11);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_count", op_count, 0);
    chk("mid_rst_result", result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    single_op("add_ovf",   4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 5'b01100);
    single_op("add_carry", 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0,         5'b00011);
    single_op("sub_lt",    4'b0110, 32'd5, 32'd7,         32'hFFFF_FFFE, 5'b01000);
    single_op("sub_ge",    4'b0110, 32'd7, 32'd5,         32'h2,         5'b00010);
    single_op("sub_ovf",   4'b0110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 5'b00110);
    single_op("and",       4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 5'b00000);
    single_op("or",        4'b0001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 5'b01000);
    single_op("nop",       4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0,         5'b00001);
    single_op("illegal",   4'b0101, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0,         5'b10001);
    chk("count_after_vectors", op_count, 9);

    // Back-pressure: 4 ops streamed while the output is stalled for 6 cycles.
    bp_sel[0] = 4'b0010; bp_a[0] = 32'd1;   bp_b[0] = 32'd2;   bp_exp[0] = 32'd3;
    bp_sel[1] = 4'b0010; bp_a[1] = 32'd10;  bp_b[1] = 32'd20;  bp_exp[1] = 32'd30;
    bp_sel[2] = 4'b0010; bp_a[2] = 32'd100; bp_b[2] = 32'd200; bp_exp[2] = 32'd300;
    bp_sel[3] = 4'b0110; bp_a[3] = 32'd50;  bp_b[3] = 32'd8;   bp_exp[3] = 32'd42;
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    out_ready = 1'b0;
    ii = 0; oi = 0; acc_rel = 0;
    in_valid = 1'b1; alusel = bp_sel[0]; op_a = bp_a[0]; op_b = bp_b[0];
    for (int cyc = 0; cyc < 30 && oi < 4; cyc++) begin
      @(negedge clk);
      fin  = in_valid && in_ready;
      fout = out_valid && out_ready;
      if (fout) begin
        chk("bp_order", result, bp_exp[oi]);
        oi++;
      end
      if (!out_ready && out_valid) chk("bp_stable", result, 32'd3);
      if (!out_ready && ii >= 2) chk("bp_in_ready_low", in_ready, 0);
      @(posedge clk); #1;
      if (fin) begin
        ii++;
        if (ii < 4) begin
          alusel = bp_sel[ii]; op_a = bp_a[ii]; op_b = bp_b[ii];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (cyc == 5) begin
        acc_rel   = ii;
        out_ready = 1'b1;
      end
    end
    chk("bp_accepted_stalled", acc_rel, 2);
    chk("bp_all_drained", oi, 4);
    @(posedge clk); #1;
    chk("bp_out_valid_idle", out_valid, 0);
    chk("bp_count", op_count, 4);

    // Saturation: 17 back-to-back transfers on a 4-bit counter.
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    chk("cnt_cleared", op_count, 0);
    in_valid = 1'b1; alusel = 4'b0001; op_a = 32'h1; op_b = 32'h2;
    repeat (17) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("cnt_saturated", op_count, 15);
    chk("cnt_idle", out_valid, 0);

    // Clear coinciding with an output transfer wins.
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("clr_pre_valid", out_valid, 1);
    chk("clr_pre_count", op_count, 15);
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    chk("clr_priority", op_count, 0);
    chk("clr_drained", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
